// File: rtl/regfile_pkg.sv
// regfile_pkg: shared defaults and register types for the parametrised register file
package regfile_pkg;
    localparam int DEF_DATA_W   = 64;
    localparam int DEF_ADDR_W   = 5;
    localparam int DEF_NRD      = 2;
    localparam int ZERO_REG_DEF = 31;
    typedef logic [DEF_ADDR_W-1:0] reg_addr_t;
    typedef logic [DEF_DATA_W-1:0] reg_data_t;
endpackage

// File: rtl/regfile_if.sv
// regfile_if: read/write/reserve bus between pipeline control and the register file
interface regfile_if
    import regfile_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int NRD    = DEF_NRD
);
    logic [NRD-1:0]        rd_en;
    logic [NRD*ADDR_W-1:0] rd_addr;
    logic [NRD*DATA_W-1:0] rd_data;
    logic [NRD-1:0]        rd_valid;
    logic [NRD-1:0]        rd_pending;
    logic                  wr_en;
    logic [ADDR_W-1:0]     wr_addr;
    logic [DATA_W-1:0]     wr_data;
    logic                  rsv_en;
    logic [ADDR_W-1:0]     rsv_addr;
    logic [2**ADDR_W-1:0]  pending_vec;
    modport master (
        output rd_en, rd_addr, wr_en, wr_addr, wr_data, rsv_en, rsv_addr,
        input  rd_data, rd_valid, rd_pending, pending_vec
    );
    modport slave (
        input  rd_en, rd_addr, wr_en, wr_addr, wr_data, rsv_en, rsv_addr,
        output rd_data, rd_valid, rd_pending, pending_vec
    );
endinterface

// File: rtl/regfile_read_port.sv
// regfile_read_port: one registered read port with zero-register and write bypass select
module regfile_read_port
    import regfile_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int ZERO_REG = ZERO_REG_DEF,
    parameter int BYPASS   = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              rd_en_i,
    input  logic [ADDR_W-1:0] rd_addr_i,
    input  logic              wr_en_i,
    input  logic [ADDR_W-1:0] wr_addr_i,
    input  logic [DATA_W-1:0] wr_data_i,
    input  logic [DATA_W-1:0] arr_data_i,
    input  logic              pend_i,
    output logic [DATA_W-1:0] rd_data_o,
    output logic              rd_valid_o,
    output logic              rd_pending_o
);
    localparam logic [ADDR_W-1:0] ZR = ADDR_W'(ZERO_REG);
    logic              is_zero, byp, pend_d, pend_q, valid_q;
    logic [DATA_W-1:0] data_d, data_q;
    always_comb begin
        is_zero = rd_addr_i == ZR;
        byp     = (BYPASS != 0) && wr_en_i && wr_addr_i == rd_addr_i && !is_zero;
        data_d  = is_zero ? '0 : byp ? wr_data_i : arr_data_i;
        pend_d  = pend_i && !is_zero && !byp;
    end
    // data and pending hold across idle cycles; only valid tracks rd_en
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            data_q  <= '0;
            pend_q  <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            valid_q <= rd_en_i;
            if (rd_en_i) begin
                data_q <= data_d;
                pend_q <= pend_d;
            end
        end
    end
    assign rd_data_o    = data_q;
    assign rd_valid_o   = valid_q;
    assign rd_pending_o = pend_q;
endmodule

// File: rtl/regfile_param.sv
// regfile_param: NRD-read/1-write register file with zero register and pending scoreboard
module regfile_param
    import regfile_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int NRD      = DEF_NRD,
    parameter int ZERO_REG = ZERO_REG_DEF,
    parameter int BYPASS   = 1
) (
    input  logic      clk,
    input  logic      reset,
    regfile_if.slave  bus
);
    localparam int NREG = 2**ADDR_W;
    localparam logic [ADDR_W-1:0] ZR = ADDR_W'(ZERO_REG);
    logic [DATA_W-1:0] mem_q [NREG];
    logic [NREG-1:0]   pend_q, pend_d;
    // a reservation in the same cycle as the retiring write keeps the register pending
    always_comb begin
        pend_d = pend_q;
        if (bus.wr_en) pend_d[bus.wr_addr] = 1'b0;
        if (bus.rsv_en) pend_d[bus.rsv_addr] = 1'b1;
        pend_d[ZERO_REG] = 1'b0;
    end
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NREG; i++) mem_q[i] <= '0;
            pend_q <= '0;
        end else begin
            pend_q <= pend_d;
            if (bus.wr_en && bus.wr_addr != ZR) mem_q[bus.wr_addr] <= bus.wr_data;
        end
    end
    assign bus.pending_vec = pend_q;
    for (genvar g = 0; g < NRD; g++) begin : g_rp
        regfile_read_port #(
            .DATA_W(DATA_W), .ADDR_W(ADDR_W), .ZERO_REG(ZERO_REG), .BYPASS(BYPASS)
        ) u_rp (
            .clk          (clk),
            .reset        (reset),
            .rd_en_i      (bus.rd_en[g]),
            .rd_addr_i    (bus.rd_addr[g*ADDR_W +: ADDR_W]),
            .wr_en_i      (bus.wr_en),
            .wr_addr_i    (bus.wr_addr),
            .wr_data_i    (bus.wr_data),
            .arr_data_i   (mem_q[bus.rd_addr[g*ADDR_W +: ADDR_W]]),
            .pend_i       (pend_q[bus.rd_addr[g*ADDR_W +: ADDR_W]]),
            .rd_data_o    (bus.rd_data[g*DATA_W +: DATA_W]),
            .rd_valid_o   (bus.rd_valid[g]),
            .rd_pending_o (bus.rd_pending[g])
        );
    end
endmodule

// File: tb/tb_regfile_param.sv
// tb_regfile_param: directed bench comparing bypass and non-bypass instances against an array model
module tb_regfile_param;
    import regfile_pkg::*;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int   errors = 0;
    int   checks = 0;
    always #5 clk = ~clk;

    regfile_if #(.DATA_W(64), .ADDR_W(5), .NRD(2)) bi ();
    regfile_if #(.DATA_W(64), .ADDR_W(5), .NRD(2)) bn ();
    assign bn.rd_en    = bi.rd_en;
    assign bn.rd_addr  = bi.rd_addr;
    assign bn.wr_en    = bi.wr_en;
    assign bn.wr_addr  = bi.wr_addr;
    assign bn.wr_data  = bi.wr_data;
    assign bn.rsv_en   = bi.rsv_en;
    assign bn.rsv_addr = bi.rsv_addr;

    regfile_param #(.BYPASS(1)) dut_b (.clk(clk), .reset(reset), .bus(bi));
    regfile_param #(.BYPASS(0)) dut_n (.clk(clk), .reset(reset), .bus(bn));

    task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", n, act, exp);
        end
    endtask

    // model: index 1 = bypass instance, 0 = non-bypass instance
    logic [63:0] m_mem [32];
    logic [31:0] m_pend;
    logic [1:0]  e_valid [2];
    logic [1:0]  e_pend [2];
    logic [63:0] e_data [2][2];
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 32; i++) m_mem[i] <= '0;
            m_pend <= '0;
            for (int b = 0; b < 2; b++) begin
                e_valid[b] <= '0;
                e_pend[b]  <= '0;
                e_data[b][0] <= '0;
                e_data[b][1] <= '0;
            end
        end else begin
            for (int b = 0; b < 2; b++) begin
                for (int p = 0; p < 2; p++) begin
                    int a;
                    a = int'(bi.rd_addr[p*5 +: 5]);
                    e_valid[b][p] <= bi.rd_en[p];
                    if (bi.rd_en[p]) begin
                        if (a == 31) begin
                            e_data[b][p] <= '0;
                            e_pend[b][p] <= 1'b0;
                        end else if (b == 1 && bi.wr_en && int'(bi.wr_addr) == a) begin
                            e_data[b][p] <= bi.wr_data;
                            e_pend[b][p] <= 1'b0;
                        end else begin
                            e_data[b][p] <= m_mem[a];
                            e_pend[b][p] <= m_pend[a];
                        end
                    end
                end
            end
            if (bi.wr_en && bi.wr_addr != 5'd31) m_mem[bi.wr_addr] <= bi.wr_data;
            if (bi.wr_en) m_pend[bi.wr_addr] <= 1'b0;
            if (bi.rsv_en && bi.rsv_addr != 5'd31) m_pend[bi.rsv_addr] <= 1'b1;
        end
    end

    always @(negedge clk) begin
        chk("bi.pending_vec", 64'(bi.pending_vec), 64'(m_pend));
        chk("bn.pending_vec", 64'(bn.pending_vec), 64'(m_pend));
        chk("bi.rd_valid", 64'(bi.rd_valid), 64'(e_valid[1]));
        chk("bn.rd_valid", 64'(bn.rd_valid), 64'(e_valid[0]));
        chk("bi.rd_pending", 64'(bi.rd_pending), 64'(e_pend[1]));
        chk("bn.rd_pending", 64'(bn.rd_pending), 64'(e_pend[0]));
        for (int p = 0; p < 2; p++) begin
            chk($sformatf("bi.rd_data%0d", p), bi.rd_data[p*64 +: 64], e_data[1][p]);
            chk($sformatf("bn.rd_data%0d", p), bn.rd_data[p*64 +: 64], e_data[0][p]);
        end
    end

    task automatic idle();
        bi.rd_en = '0; bi.rd_addr = '0; bi.wr_en = 1'b0; bi.wr_addr = '0;
        bi.wr_data = '0; bi.rsv_en = 1'b0; bi.rsv_addr = '0;
    endtask

    task automatic rd(input logic [1:0] en, input reg_addr_t a1, input reg_addr_t a0);
        bi.rd_en = en; bi.rd_addr = {a1, a0};
    endtask

    task automatic wr(input reg_addr_t a, input logic [63:0] d);
        bi.wr_en = 1'b1; bi.wr_addr = a; bi.wr_data = d;
    endtask

    task automatic rsv(input reg_addr_t a);
        bi.rsv_en = 1'b1; bi.rsv_addr = a;
    endtask

    initial begin
        idle();
        #1 reset = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset valid", 64'(bi.rd_valid), 64'd0);
        chk("reset data", bi.rd_data[63:0], 64'd0);
        reset = 1'b1;
        rd(2'b11, 5'd3, 5'd0);
        @(negedge clk);
        chk("first valid", 64'(bi.rd_valid), 64'd3);
        chk("first data1", bi.rd_data[127:64], 64'd0);
        chk("first pend", 64'(bi.rd_pending), 64'd0);
        chk("first pvec", 64'(bi.pending_vec), 64'd0);
        idle(); wr(5'd5, 64'hDEAD_BEEF_0123_4567);
        @(negedge clk);
        idle(); rd(2'b01, 5'd0, 5'd5);
        @(negedge clk);
        chk("wr-rd x5", bi.rd_data[63:0], 64'hDEAD_BEEF_0123_4567);
        idle(); wr(5'd7, 64'h11); rd(2'b11, 5'd7, 5'd7);
        @(negedge clk);
        chk("byp1 p0", bi.rd_data[63:0], 64'h11);
        chk("byp1 p1", bi.rd_data[127:64], 64'h11);
        chk("byp0 p0", bn.rd_data[63:0], 64'h0);
        chk("byp0 p1", bn.rd_data[127:64], 64'h0);
        idle(); rd(2'b11, 5'd7, 5'd7);
        @(negedge clk);
        chk("byp0 after", bn.rd_data[127:64], 64'h11);
        idle(); wr(5'd31, '1); rsv(5'd31);
        @(negedge clk);
        idle(); rd(2'b11, 5'd31, 5'd31);
        @(negedge clk);
        chk("x31 data", bi.rd_data[63:0], 64'd0);
        chk("x31 pend", 64'(bi.rd_pending), 64'd0);
        chk("x31 pvec", 64'(bi.pending_vec[31]), 64'd0);
        idle(); rsv(5'd9);
        @(negedge clk);
        chk("rsv x9", 64'(bi.pending_vec[9]), 64'd1);
        idle(); rd(2'b01, 5'd0, 5'd9);
        @(negedge clk);
        chk("rd x9 pend", 64'(bi.rd_pending[0]), 64'd1);
        idle(); wr(5'd9, 64'h99); rsv(5'd9);
        @(negedge clk);
        chk("wr+rsv x9", 64'(bi.pending_vec[9]), 64'd1);
        idle(); wr(5'd9, 64'h9A); rd(2'b10, 5'd9, 5'd0);
        @(negedge clk);
        chk("wr x9 clr", 64'(bi.pending_vec[9]), 64'd0);
        chk("byp1 pend", 64'(bi.rd_pending[1]), 64'd0);
        chk("byp0 pend", 64'(bn.rd_pending[1]), 64'd1);
        for (int i = 0; i < 6; i++) begin
            idle();
            wr(reg_addr_t'(10 + i), 64'h0123_0000_0000_1000 + 64'(i * 17));
            rsv(reg_addr_t'(20 + i));
            rd(2'b11, reg_addr_t'(19 + i), reg_addr_t'(10 + i));
            @(negedge clk);
        end
        idle(); rd(2'b11, 5'd7, 5'd5);
        @(posedge clk);
        #2 reset = 1'b0;
        #1;
        chk("arst bi valid", 64'(bi.rd_valid), 64'd0);
        chk("arst bn valid", 64'(bn.rd_valid), 64'd0);
        chk("arst pvec", 64'(bi.pending_vec), 64'd0);
        idle();
        repeat (2) @(negedge clk);
        reset = 1'b1;
        rd(2'b11, 5'd7, 5'd5);
        @(negedge clk);
        chk("post arst x5", bi.rd_data[63:0], 64'd0);
        chk("post arst x7", bn.rd_data[127:64], 64'd0);
        idle();
        @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/regfile_param.md
Name: regfile_param

Overview:
Parametrised successor to the 32x64 logic-gate register file. It provides N read ports with registered (1-cycle) outputs, one write port with same-cycle write-to-read bypass, and a hard-wired zero register. A per-register pending scoreboard lets the pipeline control detect RAW hazards on in-flight writes. It sits between decode (reads, reservations) and writeback (writes) in the datapath.

Parameters:
DATA_W, 64, register width in bits
ADDR_W, 5, register address width; NREG = 2**ADDR_W
NRD, 2, number of read ports (1..4)
ZERO_REG, 31, index of the hard-wired zero register (reads 0, never written, never pending)
BYPASS, 1, 1 = same-cycle write data is forwarded to reads of the same address; 0 = reads return the pre-write value

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-low; asserted low clears all state
rd_en  input  NRD  per-port read request
rd_addr  input  NRD*ADDR_W  per-port read address, port p at [p*ADDR_W +: ADDR_W]
rd_data  output  NRD*DATA_W  per-port registered read data
rd_valid  output  NRD  rd_data for port p is valid this cycle
rd_pending  output  NRD  operand read by port p was pending (hazard) at request time
wr_en  input  1  write strobe
wr_addr  input  ADDR_W  write address
wr_data  input  DATA_W  write data
rsv_en  input  1  reserve a register: mark it pending
rsv_addr  input  ADDR_W  register to reserve
pending_vec  output  NREG  current scoreboard, bit i = register i pending

Behaviour:
- Reset (reset low, async): all NREG registers = 0; pending_vec = 0; rd_data = 0; rd_valid = 0; rd_pending = 0. State is held while reset is low. The first operation is accepted on the first rising edge after release.
- Read latency is 1 cycle. rd_en[p] in cycle T gives rd_valid[p]=1 and rd_data[p] in cycle T+1.
- rd_en[p]=0 in cycle T gives rd_valid[p]=0 in T+1. rd_data[p] and rd_pending[p] hold their previous values.
- Read value sampled at edge T:
  - rd_addr==ZERO_REG: returns 0.
  - BYPASS=1 and wr_en and wr_addr==rd_addr (not ZERO_REG): returns wr_data.
  - Otherwise: returns the array content before the T write.
- rd_pending[p] (T+1) = pending bit of rd_addr in cycle T, with these adjustments:
  - Cleared if a bypassed write to that address occurs in T (BYPASS=1 only).
  - Always 0 for ZERO_REG.
- Multiple ports may read the same address in the same cycle. All return identical data.
- Write: wr_en at edge T updates the register at wr_addr. wr_addr==ZERO_REG is silently dropped.
- Scoreboard update at each edge:
  - wr_en clears pending[wr_addr].
  - rsv_en sets pending[rsv_addr].
  - Same address in the same cycle: the set wins (new producer reserves after the old one retires).
  - Reserving ZERO_REG has no effect.
  - Reserving an already-pending register leaves it pending (no counting).
- A write to a non-pending register is legal and does not change pending state.
- pending_vec is the registered scoreboard, with no combinational path from inputs.
- Reset asserted mid-operation discards in-flight read results (rd_valid drops to 0 asynchronously) and all reservations.

Decomposition:
- Shared package regfile_pkg: ZERO_REG default constant, typedef reg_addr_t (logic [ADDR_W-1:0]), typedef reg_data_t (logic [DATA_W-1:0]).
- Sub-module regfile_read_port holds the zero/bypass select, the output data/valid/pending registers, and the async reset. It is instantiated NRD times by a generate loop.
- The storage array and scoreboard stay in the top level.

Test Plan:
- Reset then read: release reset, rd_en=2'b11, rd_addr={5'd3,5'd0} -> next cycle rd_valid=2'b11, rd_data both 0, rd_pending=0, pending_vec=0.
- Write then read: wr x5=64'hDEAD_BEEF_0123_4567 at T, read x5 port 0 at T+1 -> rd_data[0]=64'hDEAD_BEEF_0123_4567 at T+2.
- Bypass: same cycle wr x7=64'h11, read x7 on both ports.
  - BYPASS=1 -> both return 64'h11.
  - BYPASS=0 -> both return the old value 0; the cycle after, 64'h11.
- Zero register: write x31=64'hFFFF_FFFF_FFFF_FFFF, rsv x31, then read x31 -> rd_data=0, rd_pending=0, pending_vec[31]=0.
- Scoreboard sequence:
  - rsv x9 -> pending_vec[9]=1.
  - Read x9 -> rd_pending=1.
  - Same-cycle wr x9 + rsv x9 -> pending_vec[9] stays 1.
  - wr x9 alone -> pending_vec[9]=0.
- Async reset mid-read: rd_en at T, reset low between edges -> rd_valid=0 and pending_vec=0 immediately. All registers read 0 after release.
